// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module  : fifo_uart_tx
// Purpose : Pops bytes from a synchronous FIFO read port and sends each one as
//           an LSB-first UART frame. Define PARITY_EN to add an even parity bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
  parameter int D_WIDTH      = 8,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               empty,
  input  logic [D_WIDTH-1:0] r_data,
  output logic               rd,
  output logic               tx,
  output logic               busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [CW-1:0] C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] C_BIT_LAST  = BW'(D_WIDTH - 1);

  // Timed states are encoded at or above S_START so the baud counter gate is a compare.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
`ifdef PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd6;
`endif

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      baud_q, baud_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [D_WIDTH-1:0] shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               rd_q, rd_d;
  logic               busy_q, busy_d;
  logic               baud_end;
`ifdef PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign baud_end = (baud_q == C_BAUD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_POP;
      S_POP:   state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (baud_end) state_d = S_DATA;
      S_DATA: begin
        if (baud_end && (bit_q == C_BIT_LAST)) begin
`ifdef PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef PARITY_EN
      S_PARITY: if (baud_end) state_d = S_STOP;
`endif
      // empty is only consulted here, so mid-frame FIFO activity cannot cause a pop.
      S_STOP:  if (baud_end) state_d = empty ? S_IDLE : S_POP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    baud_d  = '0;
    bit_d   = '0;
    shift_d = shift_q;
    if ((state_q >= S_START) && (state_d == state_q) && !baud_end) begin
      baud_d = baud_q + 1'b1;
    end
    if ((state_q == S_DATA) && (state_d == S_DATA)) begin
      bit_d = baud_end ? (bit_q + 1'b1) : bit_q;
    end
    if (state_q == S_LOAD) begin
      shift_d = r_data;
    end else if ((state_q == S_DATA) && baud_end) begin
      shift_d = shift_q >> 1;
    end
`ifdef PARITY_EN
    parity_d = (state_q == S_LOAD) ? ^r_data : parity_q;
`endif
    // Outputs are decoded from the next state so they register alongside it.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    rd_d   = (state_d == S_POP);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
`ifdef PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign rd   = rd_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module  : tb_fifo_uart_tx
// Purpose : Scoreboard bench for fifo_uart_tx with a behavioural FIFO read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

  localparam int C = 4;
  localparam int D = 8;
`ifdef PARITY_EN
  localparam int NB = D + 3;
`else
  localparam int NB = D + 2;
`endif
  localparam int FRAME = NB * C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         empty = 1'b1;
  logic [D-1:0] r_data = '0;
  logic         rd, tx, busy;
  logic         wr_en = 1'b0;
  logic [D-1:0] wr_data = '0;

  logic [D-1:0] fifo_q[$];
  logic [D-1:0] exp_q[$];
  int unsigned  starts_q[$];

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          rd_cnt = 0;
  int          frames = 0;
  bit          mon_act = 1'b0;
  int          mon_idx = 0;
  bit          mon_glitch = 1'b0;
  logic [NB-1:0] mon_bits = '0;

  fifo_uart_tx #(.D_WIDTH(D), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .empty(empty), .r_data(r_data),
    .rd(rd), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO read port: registered data and empty flag, data valid the cycle after rd.
  always @(posedge clk) begin
    if (rd === 1'b1) begin
      check("rd_nonempty", (fifo_q.size() > 0), 1);
      if (fifo_q.size() > 0) r_data <= fifo_q.pop_front();
    end
    if (wr_en) fifo_q.push_back(wr_data);
    empty <= (fifo_q.size() == 0);
  end

  task automatic frame_done();
    logic [D-1:0] got;
    logic [D-1:0] e;
    frames++;
    got = mon_bits[D:1];
    check("start_bit", mon_bits[0], 0);
    check("stop_bit", mon_bits[NB-1], 1);
    check("bit_glitch", mon_glitch, 0);
    if (exp_q.size() == 0) begin
      check("frame_expected", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("frame_data", got, e);
`ifdef PARITY_EN
      check("parity_bit", mon_bits[D+1], ^e);
`endif
    end
  endtask

  // Line monitor: every sample of each bit period must equal its first sample.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      mon_act = 1'b0;
    end else begin
      if (rd === 1'b1) rd_cnt++;
      if (!mon_act && tx === 1'b0) begin
        mon_act    = 1'b1;
        mon_idx    = 0;
        mon_glitch = 1'b0;
        starts_q.push_back(cyc);
      end
      if (mon_act) begin
        if (mon_idx % C == 0) mon_bits[mon_idx / C] = tx;
        else if (tx !== mon_bits[mon_idx / C]) mon_glitch = 1'b1;
        mon_idx++;
        if (mon_idx == FRAME) begin
          mon_act = 1'b0;
          frame_done();
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [D-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(busy === 1'b0 && empty === 1'b1 && !mon_act) && n < 2000) begin
      tick();
      n++;
    end
    check("idle_timeout", (n < 2000), 1);
  endtask

  task automatic wait_start(input int n0);
    int n = 0;
    while (starts_q.size() <= n0 && n < 500) begin
      tick();
      n++;
    end
    check("start_timeout", (starts_q.size() > n0), 1);
  endtask

  initial begin : main
    int n, r0, f0, s0;
    #1 rst = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_rd", rd, 0);
    check("rst_busy", busy, 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (10) tick();
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    check("idle_rd_cnt", rd_cnt, 0);

    // Single byte
    r0 = rd_cnt; f0 = frames;
    push(8'hA5);
    n = 0;
    while (busy !== 1'b1 && n < 50) begin tick(); n++; end
    n = 0;
    while (busy === 1'b1 && n < 500) begin n++; tick(); end
    check("busy_len", n, FRAME + 2);
    wait_idle();
    check("single_rd", rd_cnt - r0, 1);
    check("single_frames", frames - f0, 1);
    check("single_empty", empty, 1);

    // Burst of eight
    r0 = rd_cnt; f0 = frames; s0 = starts_q.size();
    for (int i = 0; i < 8; i++) push(D'(i));
    wait_idle();
    check("burst_rd", rd_cnt - r0, 8);
    check("burst_frames", frames - f0, 8);
    for (int i = 1; i < 8; i++)
      check("burst_gap", starts_q[s0 + i] - starts_q[s0 + i - 1], FRAME + 2);

    // Write arriving mid-frame
    f0 = frames; s0 = starts_q.size();
    push(8'h0F);
    wait_start(s0);
    repeat (10) tick();
    push(8'hFF);
    wait_idle();
    check("late_frames", frames - f0, 2);
    check("late_gap", starts_q[s0 + 1] - starts_q[s0], FRAME + 2);

    // Reset during data bit 3 (0x35 has bit 3 = 0)
    r0 = rd_cnt; f0 = frames; s0 = starts_q.size();
    push(8'h35);
    push(8'hC3);
    wait_start(s0);
    repeat (4 * C + 1) tick();
    check("pre_abort_tx", tx, 0);
    rst = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    void'(exp_q.pop_front());
    repeat (2) tick();
    rst = 1'b1;
    wait_idle();
    check("abort_frames", frames - f0, 1);
    check("abort_rd", rd_cnt - r0, 2);
    check("abort_empty", empty, 1);

`ifdef PARITY_EN
    f0 = frames;
    push(8'h03);
    push(8'h07);
    push(8'hFF);
    wait_idle();
    check("parity_frames", frames - f0, 3);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
